// File: rtl/audvid_output_core.sv
// AudVid output core: SPI work strobes, Philips I2S serializer fed by a phase
// accumulator, and a CGA-order RGB565 palette for the TFT colour index.
`timescale 1ns/1ps

module audvid_output_core #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned SAMPLE_HZ = 41_000,
    parameter logic [31:0] NCO_INC   = 32'd112_699_942
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [3:0]  ColorIndex,
    output logic [15:0] Rgb565,
    input  logic [31:0] SampleData,
    output logic        SampleRequest,
    output logic        I2S_CLK,
    output logic        I2S_WS,
    output logic        I2S_DATA,
    output logic        TftTick,
    output logic        SdTick
);

    // A zero NCO_INC falls back to the increment derived from the two frequencies.
    localparam longint unsigned DERIVED_INC =
        ((64'(SAMPLE_HZ) << 38) + (64'(CLK_HZ) >> 1)) / 64'(CLK_HZ);
    localparam logic [31:0] INC = (NCO_INC != 32'd0) ? NCO_INC : DERIVED_INC[31:0];

    logic [2:0]  sdCnt;
    logic [3:0]  tftCnt;
    logic [31:0] phaseAcc;
    logic [32:0] phaseSum;
    logic        edgeTick;
    logic        i2sClkReg;
    logic        fallEdge;
    logic        frameStart;
    logic [4:0]  slot;
    logic [4:0]  nextSlot;
    logic [4:0]  bitSel;
    logic [31:0] frameReg;
    logic        wsReg;
    logic        dataReg;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            sdCnt  <= '0;
            tftCnt <= '0;
        end else begin
            sdCnt  <= sdCnt + 3'd1;
            tftCnt <= tftCnt + 4'd1;
        end
    end

    assign SdTick  = &sdCnt;
    assign TftTick = &tftCnt;

    assign phaseSum   = {1'b0, phaseAcc} + {1'b0, INC};
    assign edgeTick   = phaseSum[32];
    assign fallEdge   = edgeTick & i2sClkReg;
    assign frameStart = fallEdge & (slot == 5'd31);
    assign nextSlot   = slot + 5'd1;
    // Philips one-bit delay: slot s carries frame bit (32 - s) mod 32.
    assign bitSel     = 5'd0 - nextSlot;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            phaseAcc  <= '0;
            i2sClkReg <= 1'b0;
            slot      <= '0;
            frameReg  <= '0;
            wsReg     <= 1'b0;
            dataReg   <= 1'b0;
        end else begin
            phaseAcc <= phaseSum[31:0];
            if (edgeTick) begin
                i2sClkReg <= ~i2sClkReg;
            end
            // Slot 0 still shows right[0] of the outgoing word, read before the reload.
            if (fallEdge) begin
                slot    <= nextSlot;
                wsReg   <= nextSlot[4];
                dataReg <= frameReg[bitSel];
                if (frameStart) begin
                    frameReg <= SampleData;
                end
            end
        end
    end

    assign SampleRequest = frameStart;
    assign I2S_CLK       = i2sClkReg;
    assign I2S_WS        = wsReg;
    assign I2S_DATA      = dataReg;

    always_comb begin
        Rgb565 = 16'h0000;
        case (ColorIndex)
            4'd0:  Rgb565 = 16'h0000;
            4'd1:  Rgb565 = 16'h0015;
            4'd2:  Rgb565 = 16'h0540;
            4'd3:  Rgb565 = 16'h0555;
            4'd4:  Rgb565 = 16'hA800;
            4'd5:  Rgb565 = 16'hA815;
            4'd6:  Rgb565 = 16'hAAA0;
            4'd7:  Rgb565 = 16'hAD55;
            4'd8:  Rgb565 = 16'h52AA;
            4'd9:  Rgb565 = 16'h52BF;
            4'd10: Rgb565 = 16'h57EA;
            4'd11: Rgb565 = 16'h57FF;
            4'd12: Rgb565 = 16'hFAAA;
            4'd13: Rgb565 = 16'hFABF;
            4'd14: Rgb565 = 16'hFFEA;
            4'd15: Rgb565 = 16'hFFFF;
            default: Rgb565 = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_audvid_output_core.sv
// Directed self-checking bench for audvid_output_core: palette, strobes,
// I2S framing against a slot-tracking monitor, reset abort, handoff and rate.
`timescale 1ns/1ps

module tb_audvid_output_core;

    logic        clock = 1'b0;
    logic        resetN;
    logic [3:0]  colorIndex;
    logic [15:0] rgb565;
    logic [31:0] sampleData;
    logic        sampleRequest;
    logic        i2sClk;
    logic        i2sWs;
    logic        i2sData;
    logic        tftTick;
    logic        sdTick;

    int errorCount = 0;
    int checkCount = 0;

    logic [15:0] palette [16] = '{16'h0000, 16'h0015, 16'h0540, 16'h0555,
                                  16'hA800, 16'hA815, 16'hAAA0, 16'hAD55,
                                  16'h52AA, 16'h52BF, 16'h57EA, 16'h57FF,
                                  16'hFAAA, 16'hFABF, 16'hFFEA, 16'hFFFF};
    logic [31:0] handoffTable [3] = '{32'h1234_8001, 32'hFFFF_0000, 32'h8000_7FFE};

    // Monitor state: bench-side slot tracking and per-frame capture.
    int          monSlot;
    int          monRiseCnt;
    logic        monPrevClk;
    logic        monPrevReq;
    logic        monHasReq;
    logic        monPendReq;
    logic        monFalling;
    logic        monRising;
    logic [31:0] monCap;
    logic [31:0] monWs;
    logic [31:0] monFrameExp;
    logic [31:0] monPendExp;
    logic [31:0] rxQ [$];

    always #5 clock = ~clock;

    audvid_output_core dut (
        .CLK           (clock),
        .Reset         (resetN),
        .ColorIndex    (colorIndex),
        .Rgb565        (rgb565),
        .SampleData    (sampleData),
        .SampleRequest (sampleRequest),
        .I2S_CLK       (i2sClk),
        .I2S_WS        (i2sWs),
        .I2S_DATA      (i2sData),
        .TftTick       (tftTick),
        .SdTick        (sdTick)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] idx);
        colorIndex = idx;
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_i2s_clk"}, 32'(i2sClk), 32'd0);
        checkOutput({tag, "_i2s_ws"}, 32'(i2sWs), 32'd0);
        checkOutput({tag, "_i2s_data"}, 32'(i2sData), 32'd0);
        checkOutput({tag, "_sample_req"}, 32'(sampleRequest), 32'd0);
        checkOutput({tag, "_tft_tick"}, 32'(tftTick), 32'd0);
        checkOutput({tag, "_sd_tick"}, 32'(sdTick), 32'd0);
    endtask

    task automatic waitFrames(input int n, input int budget, input string tag);
        int c = 0;
        while (rxQ.size() < n && c < budget) begin
            @(posedge clock);
            #2;
            c++;
        end
        checkOutput({tag, "_frame_count"}, 32'(rxQ.size()), 32'(n));
    endtask

    task automatic waitRequest(input int budget, input string tag);
        int c = 0;
        while (sampleRequest !== 1'b1 && c < budget) begin
            @(posedge clock);
            #2;
            c++;
        end
        checkOutput({tag, "_req_seen"}, 32'(sampleRequest), 32'd1);
    endtask

    // Samples every CLK after the edge; data and WS are taken on I2S rising edges.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (resetN !== 1'b1) begin
                monSlot = 0; monRiseCnt = 0; monPrevClk = 0; monPrevReq = 0;
                monHasReq = 0; monPendReq = 0; monCap = '0; monWs = '0;
                monFrameExp = '0; monPendExp = '0;
            end else begin
                monFalling = monPrevClk && !i2sClk;
                monRising  = !monPrevClk && i2sClk;
                if (monFalling) monSlot = (monSlot + 1) % 32;
                if (monPrevReq || (monFalling && monSlot == 0))
                    checkOutput("req_at_wrap", 32'(monPrevReq), 32'(monFalling && monSlot == 0));
                if (monRising) begin
                    monRiseCnt++;
                    monCap[(32 - monSlot) % 32] = i2sData;
                    monWs[monSlot] = i2sWs;
                    if (monSlot == 0) begin
                        if (monRiseCnt == 32) begin
                            checkOutput("frame_data", monCap, monFrameExp);
                            checkOutput("frame_ws", monWs, 32'hFFFF_0000);
                            if (monHasReq) rxQ.push_back(monCap);
                        end
                        monFrameExp = monPendExp;
                        monHasReq   = monPendReq;
                        monPendReq  = 0;
                        monCap      = '0;
                        monWs       = '0;
                        monRiseCnt  = 0;
                    end
                end
                if (sampleRequest) begin
                    monPendExp = sampleData;
                    monPendReq = 1;
                end
                monPrevClk = i2sClk;
                monPrevReq = sampleRequest;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errorCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sdCount, tftCount, firstSd, firstTft, sdPatErr, tftPatErr;
        int reqCount, riseCount, lastReq, minGap, c;
        logic prevClk;
        logic [31:0] word;

        resetN     = 1'b1;
        colorIndex = 4'd0;
        sampleData = 32'hA5C3_0F81;
        #3 resetN  = 1'b0;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(4'(i));
            checkOutput($sformatf("rgb_idx%0d", i), 32'(rgb565), 32'(palette[i]));
        end
        applyStimulus(4'd4);
        checkOutput("rgb_red_a800", 32'(rgb565), 32'h0000_A800);
        applyStimulus(4'd15);
        checkOutput("rgb_white_ffff", 32'(rgb565), 32'h0000_FFFF);

        repeat (3) @(posedge clock);
        #2;
        checkIdle("in_reset");

        // Dividers: sample k is taken just before CLK edge k after release.
        @(posedge clock);
        #2 resetN = 1'b1;
        sdCount = 0; tftCount = 0; firstSd = 0; firstTft = 0; sdPatErr = 0; tftPatErr = 0;
        for (int k = 1; k <= 160; k++) begin
            @(negedge clock);
            if (sdTick === 1'b1) begin
                sdCount++;
                if (firstSd == 0) firstSd = k;
            end
            if (tftTick === 1'b1) begin
                tftCount++;
                if (firstTft == 0) firstTft = k;
            end
            if (sdTick !== ((k % 8) == 0)) sdPatErr++;
            if (tftTick !== ((k % 16) == 0)) tftPatErr++;
        end
        checkOutput("sd_count_160", 32'(sdCount), 32'd20);
        checkOutput("tft_count_160", 32'(tftCount), 32'd10);
        checkOutput("sd_first_edge", 32'(firstSd), 32'd8);
        checkOutput("tft_first_edge", 32'(firstTft), 32'd16);
        checkOutput("sd_pattern_errs", 32'(sdPatErr), 32'd0);
        checkOutput("tft_pattern_errs", 32'(tftPatErr), 32'd0);

        // Two frames of a held sample.
        waitFrames(2, 9000, "held");
        if (rxQ.size() >= 2) begin
            checkOutput("held_frame1", rxQ[0], 32'hA5C3_0F81);
            word = rxQ[0];
            checkOutput("held_frame1_left", 32'(word[31:16]), 32'h0000_A5C3);
            word = rxQ[1];
            checkOutput("held_frame2_right", 32'(word[15:0]), 32'h0000_0F81);
        end

        // Abort mid-frame at slot 9.
        c = 0;
        while (monSlot != 9 && c < 3000) begin
            @(posedge clock);
            #2;
            c++;
        end
        checkOutput("reached_slot9", 32'(monSlot), 32'd9);
        @(negedge clock);
        resetN = 1'b0;
        #1;
        checkIdle("mid_reset");
        sampleData = 32'h3C5A_96E1;
        repeat (4) @(posedge clock);
        rxQ.delete();
        #2 resetN = 1'b1;
        waitFrames(1, 6000, "after_reset");
        if (rxQ.size() >= 1)
            checkOutput("after_reset_frame", rxQ[0], 32'h3C5A_96E1);

        // Handoff: change data one CLK after each request.
        rxQ.delete();
        sampleData = handoffTable[0];
        for (int i = 0; i < 3; i++) begin
            waitRequest(3000, $sformatf("handoff%0d", i));
            @(posedge clock);
            #2;
            sampleData = (i < 2) ? handoffTable[i + 1] : 32'hDEAD_BEEF;
        end
        waitFrames(4, 3500, "handoff");
        if (rxQ.size() >= 4) begin
            checkOutput("handoff_prev", rxQ[0], 32'h3C5A_96E1);
            for (int i = 0; i < 3; i++)
                checkOutput($sformatf("handoff_frame%0d", i), rxQ[i + 1], handoffTable[i]);
        end

        // Rate over 30000 CLK: about 787.2 edge ticks and 12.3 frames expected.
        reqCount = 0; riseCount = 0; lastReq = -100000; minGap = 1000000;
        prevClk = i2sClk;
        for (int k = 0; k < 30000; k++) begin
            @(posedge clock);
            #2;
            if (i2sClk && !prevClk) riseCount++;
            prevClk = i2sClk;
            if (sampleRequest) begin
                reqCount++;
                if (k - lastReq < minGap) minGap = k - lastReq;
                lastReq = k;
            end
        end
        $display("[TB] rate window: requests=%0d rising=%0d min_gap=%0d", reqCount, riseCount, minGap);
        checkOutput("rate_req_in_12_13", 32'(reqCount >= 12 && reqCount <= 13), 32'd1);
        checkOutput("rate_rise_in_393_394", 32'(riseCount >= 393 && riseCount <= 394), 32'd1);
        checkOutput("rate_req_gap_ge_32", 32'(minGap >= 32), 32'd1);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
